// File: rtl/freq_meas_controller.sv
// Period meter: triggers on a hysteretic threshold crossing, averages 2^AVG_LOG2
// periods measured in sample ticks, with a per-state watchdog timeout.
module freq_meas_controller #(
    parameter int unsigned AVG_LOG2        = 2,
    parameter int unsigned TIMEOUT_SAMPLES = 20000,
    parameter int unsigned HYST            = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        SAMPLE_EN,
    input  logic        SIG_MODE,
    input  logic        START,
    input  logic [8:0]  DATA_IN,
    input  logic [8:0]  TRIGGER,
    input  logic        RESULT_ACK,
    output logic [15:0] PERIOD_OUT,
    output logic        RESULT_VALID,
    output logic        TIMEOUT_FLAG,
    output logic        BUSY
);

    localparam int unsigned ACC_W   = 16 + AVG_LOG2;
    localparam int unsigned IDX_W   = AVG_LOG2 + 1;
    localparam int unsigned NUM_PER = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RISE1,
        ST_MEAS_LOW,
        ST_MEAS_HIGH,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        tick_q, tick_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        wd_q, wd_d;
    logic [15:0]        period_q, period_d;
    logic               valid_q, valid_d;
    logic               tflag_q, tflag_d;
    logic               busy_q, busy_d;

    logic [9:0]         hi_sum, hi_thr, lo_thr;
    logic               cross_hi, cross_lo, timeout;
    logic [16:0]        wd_inc;
    logic [15:0]        tick_inc;
    logic [ACC_W-1:0]   acc_sum;
    logic [IDX_W-1:0]   idx_inc;

    // Thresholds are formed at 10 bits and clamped so TRIGGER near 0/511 cannot wrap.
    always_comb begin
        hi_sum   = {1'b0, TRIGGER} + 10'(HYST);
        hi_thr   = (hi_sum > 10'd511) ? 10'd511 : hi_sum;
        lo_thr   = ({1'b0, TRIGGER} >= 10'(HYST)) ? ({1'b0, TRIGGER} - 10'(HYST)) : '0;
        cross_hi = SAMPLE_EN && ({1'b0, DATA_IN} > hi_thr);
        cross_lo = SAMPLE_EN && ({1'b0, DATA_IN} < lo_thr);
        wd_inc   = {1'b0, wd_q} + 17'd1;
        timeout  = SAMPLE_EN && (wd_inc >= 17'(TIMEOUT_SAMPLES));
        tick_inc = tick_q + 16'd1;
        acc_sum  = acc_q + ACC_W'(tick_inc);
        idx_inc  = idx_q + IDX_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        wd_d     = SAMPLE_EN ? wd_inc[15:0] : wd_q;
        period_d = period_q;
        tflag_d  = tflag_q;

        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (START && SIG_MODE) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!SIG_MODE)     state_d = ST_IDLE;
                else if (cross_lo) state_d = ST_RISE1;
                else if (timeout) begin
                    state_d  = ST_DONE;
                    period_d = '0;
                    tflag_d  = 1'b1;
                end
            end
            ST_RISE1: begin
                if (!SIG_MODE) state_d = ST_IDLE;
                else if (cross_hi) begin
                    state_d = ST_MEAS_LOW;
                    tick_d  = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                end else if (timeout) begin
                    state_d  = ST_DONE;
                    period_d = '0;
                    tflag_d  = 1'b1;
                end
            end
            ST_MEAS_LOW: begin
                if (SAMPLE_EN) tick_d = tick_inc;
                if (!SIG_MODE)     state_d = ST_IDLE;
                else if (cross_lo) state_d = ST_MEAS_HIGH;
                else if (timeout) begin
                    state_d  = ST_DONE;
                    period_d = '0;
                    tflag_d  = 1'b1;
                end
            end
            ST_MEAS_HIGH: begin
                if (SAMPLE_EN) tick_d = tick_inc;
                if (!SIG_MODE) state_d = ST_IDLE;
                else if (cross_hi) begin
                    acc_d  = acc_sum;
                    tick_d = '0;
                    idx_d  = idx_inc;
                    if (idx_inc == IDX_W'(NUM_PER)) begin
                        state_d  = ST_DONE;
                        period_d = 16'(acc_sum >> AVG_LOG2);
                        tflag_d  = 1'b0;
                    end else begin
                        state_d = ST_MEAS_LOW;
                    end
                end else if (timeout) begin
                    state_d  = ST_DONE;
                    period_d = '0;
                    tflag_d  = 1'b1;
                end
            end
            ST_DONE: begin
                wd_d = '0;
                if (RESULT_ACK) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Every transition restarts the watchdog.
        if (state_d != state_q) wd_d = '0;
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            wd_q     <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            tflag_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            tflag_q  <= tflag_d;
            busy_q   <= busy_d;
        end
    end

    assign PERIOD_OUT   = period_q;
    assign RESULT_VALID = valid_q;
    assign TIMEOUT_FLAG = tflag_q;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_freq_meas_controller.sv
// Scoreboard bench for freq_meas_controller: expected results are queued when a
// measurement is launched and compared when RESULT_VALID rises.
module tb_freq_meas_controller;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        SAMPLE_EN = 1'b0;
    logic        SIG_MODE = 1'b1;
    logic        START = 1'b0;
    logic [8:0]  DATA_IN = '0;
    logic [8:0]  TRIGGER = 9'd250;
    logic        RESULT_ACK = 1'b0;
    logic [15:0] PERIOD_OUT;
    logic        RESULT_VALID;
    logic        TIMEOUT_FLAG;
    logic        BUSY;

    typedef struct {
        logic [15:0] period;
        logic        tflag;
    } result_t;

    result_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    logic prev_valid = 1'b0;

    freq_meas_controller #(
        .AVG_LOG2(2),
        .TIMEOUT_SAMPLES(50),
        .HYST(2)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .SAMPLE_EN(SAMPLE_EN),
        .SIG_MODE(SIG_MODE),
        .START(START),
        .DATA_IN(DATA_IN),
        .TRIGGER(TRIGGER),
        .RESULT_ACK(RESULT_ACK),
        .PERIOD_OUT(PERIOD_OUT),
        .RESULT_VALID(RESULT_VALID),
        .TIMEOUT_FLAG(TIMEOUT_FLAG),
        .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // Result monitor: pops one expectation per RESULT_VALID rising edge.
    always @(negedge CLOCK) begin
        if (RESULT_VALID && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 32'(PERIOD_OUT), 32'hFFFF_FFFF);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                check_eq("period_out", 32'(PERIOD_OUT), 32'(e.period));
                check_eq("timeout_flag", 32'(TIMEOUT_FLAG), 32'(e.tflag));
            end
        end
        prev_valid = RESULT_VALID;
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic sample(input logic [8:0] d);
        DATA_IN   = d;
        SAMPLE_EN = 1'b1;
        tick();
        SAMPLE_EN = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] p, input logic f);
        result_t e;
        e.period = p;
        e.tflag  = f;
        exp_q.push_back(e);
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic ack_result();
        RESULT_ACK = 1'b1;
        tick();
        RESULT_ACK = 1'b0;
        check_eq("valid_after_ack", 32'(RESULT_VALID), 32'd0);
        check_eq("busy_after_ack", 32'(BUSY), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {13'd0, PERIOD_OUT, RESULT_VALID, TIMEOUT_FLAG, BUSY}, 32'd0);
    endtask

    // Square wave: after the first rise, each period p is p/2 high then the rest low,
    // ending on the next rising sample.
    task automatic measure(input int p0, input int p1, input int p2, input int p3,
                           input bit poke_start);
        int per[4];
        int sum;
        int h;
        per = '{p0, p1, p2, p3};
        sum = p0 + p1 + p2 + p3;
        push_exp(16'(sum >> 2), 1'b0);
        pulse_start();
        sample(9'd100);
        sample(9'd100);
        sample(9'd400);
        for (int i = 0; i < 4; i++) begin
            h = per[i] / 2;
            repeat (h - 1) sample(9'd400);
            repeat (per[i] - h) sample(9'd100);
            if (i == 1 && poke_start) pulse_start();
            sample(9'd400);
        end
        sample(9'd400);
    endtask

    initial begin
        repeat (3) tick();
        check_all_zero("reset_state");
        RESET = 1'b0;
        tick();
        check_all_zero("idle_after_reset");

        // START ignored in DC mode
        SIG_MODE = 1'b0;
        pulse_start();
        tick();
        check_eq("dc_start_ignored", 32'(BUSY), 32'd0);
        SIG_MODE = 1'b1;

        // Nominal and averaging/truncation cases
        measure(10, 10, 10, 10, 1'b0);
        wait_result("wait_sq10");
        check_eq("busy_in_done", 32'(BUSY), 32'd1);
        ack_result();
        measure(9, 10, 10, 11, 1'b0);
        wait_result("wait_avg10");
        ack_result();
        measure(9, 9, 9, 10, 1'b1);
        wait_result("wait_trunc9");
        ack_result();
        measure(4, 12, 7, 20, 1'b0);
        wait_result("wait_mixed");
        ack_result();

        // Timeout in ARM with constant input above trigger
        push_exp(16'd0, 1'b1);
        pulse_start();
        repeat (49) sample(9'd300);
        check_eq("no_early_timeout", 32'(RESULT_VALID), 32'd0);
        check_eq("busy_in_arm", 32'(BUSY), 32'd1);
        sample(9'd300);
        wait_result("wait_timeout");
        ack_result();

        // Signal inside the hysteresis band never leaves ARM, so it times out at 50
        push_exp(16'd0, 1'b1);
        pulse_start();
        for (int i = 0; i < 50; i++) sample(9'(248 + (i % 5)));
        wait_result("wait_hyst_band");
        ack_result();

        // TRIGGER = 0: LO clamps to 0, nothing crosses low
        TRIGGER = 9'd0;
        push_exp(16'd0, 1'b1);
        pulse_start();
        repeat (50) sample(9'd0);
        wait_result("wait_trig0");
        ack_result();

        // TRIGGER = 511: HI clamps to 511, nothing crosses high from RISE1
        TRIGGER = 9'd511;
        push_exp(16'd0, 1'b1);
        pulse_start();
        sample(9'd0);
        repeat (49) sample(9'd511);
        check_eq("trig511_no_early", 32'(RESULT_VALID), 32'd0);
        sample(9'd511);
        wait_result("wait_trig511");
        ack_result();
        TRIGGER = 9'd250;

        // SIG_MODE drops in MEAS_HIGH
        pulse_start();
        sample(9'd100);
        sample(9'd400);
        sample(9'd400);
        sample(9'd100);
        SIG_MODE = 1'b0;
        tick();
        check_eq("sigmode_abort_busy", 32'(BUSY), 32'd0);
        check_eq("sigmode_abort_valid", 32'(RESULT_VALID), 32'd0);
        SIG_MODE = 1'b1;
        repeat (5) tick();

        // Reset in MEAS_LOW
        pulse_start();
        sample(9'd100);
        sample(9'd400);
        sample(9'd400);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_all_zero("reset_meas_low");

        // Reset in DONE, then a fresh measurement
        measure(10, 10, 10, 10, 1'b0);
        wait_result("wait_pre_reset");
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_all_zero("reset_done");
        measure(12, 12, 12, 12, 1'b0);
        wait_result("wait_after_reset");

        // Withheld acknowledge keeps the result stable
        begin
            int stable = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                if (PERIOD_OUT == 16'd12 && RESULT_VALID && !TIMEOUT_FLAG) stable++;
            end
            check_eq("hold_stable", 32'(stable), 32'd100);
        end
        ack_result();

        repeat (5) tick();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
